// File: rtl/lm32_wb_ram_slave_pkg.sv
// Shared encodings for the LM32 Wishbone RAM slave: bus cycle/burst types,
// FSM state encoding and the burst address-advance helper.
package lm32_wb_ram_slave_pkg;

  localparam logic [2:0] LM32_CTYPE_CLASSIC      = 3'b000;
  localparam logic [2:0] LM32_CTYPE_CONSTANT     = 3'b001;
  localparam logic [2:0] LM32_CTYPE_INCREMENTING = 3'b010;
  localparam logic [2:0] LM32_CTYPE_END          = 3'b111;

  localparam logic [1:0] LM32_BTYPE_LINEAR  = 2'b00;
  localparam logic [1:0] LM32_BTYPE_WRAP_4  = 2'b01;
  localparam logic [1:0] LM32_BTYPE_WRAP_8  = 2'b10;
  localparam logic [1:0] LM32_BTYPE_WRAP_16 = 2'b11;

  localparam int DATA_WIDTH = 32;
  localparam int SEL_WIDTH  = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SINGLE = 2'd1,
    ST_BURST  = 2'd2,
    ST_ERROR  = 2'd3
  } ram_state_t;

  // Next word index of a burst; wrapping bursts only touch the low bits.
  function automatic logic [31:0] next_index(input logic [31:0] idx,
                                             input logic [1:0]  bte);
    logic [31:0] nxt;
    nxt = idx;
    case (bte)
      LM32_BTYPE_LINEAR: nxt = idx + 32'd1;
      LM32_BTYPE_WRAP_4: nxt[1:0] = idx[1:0] + 2'd1;
      LM32_BTYPE_WRAP_8: nxt[2:0] = idx[2:0] + 3'd1;
      default:           nxt[3:0] = idx[3:0] + 4'd1;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/lm32_wb_ram_array.sv
// Single-port 32-bit RAM with byte write enables and a synchronous read port.
// Read-during-write on the same word returns the previous contents.
module lm32_wb_ram_array
  import lm32_wb_ram_slave_pkg::*;
#(
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [SEL_WIDTH-1:0]  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH)-1];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < SEL_WIDTH; i++) begin
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Only the read register is cleared; memory contents survive reset.
  always_ff @(posedge clk) begin
    if (rst) rdata <= '0;
    else if (en) rdata <= mem[addr];
  end

endmodule

// File: rtl/lm32_wb_ram_slave.sv
// Wishbone B3 RAM slave for the LM32 I/D masters: classic cycles plus
// incrementing bursts (linear/wrap4/8/16); out-of-window accesses end in ERR.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_IDLE   | no access in flight; decode request and issue the first read
// ST_SINGLE | classic/constant access: ack, optional byte write, then idle
// ST_BURST  | incrementing burst: ack each strobed in-window beat
// ST_ERROR  | out-of-window classic access: one cycle of ERR
module lm32_wb_ram_slave
  import lm32_wb_ram_slave_pkg::*;
#(
  parameter int          ADDR_WIDTH = 11,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] S_ADR_I,
  input  logic [31:0] S_DAT_I,
  input  logic [3:0]  S_SEL_I,
  input  logic        S_WE_I,
  input  logic [2:0]  S_CTI_I,
  input  logic [1:0]  S_BTE_I,
  input  logic        S_LOCK_I,
  input  logic        S_CYC_I,
  input  logic        S_STB_I,
  output logic [31:0] S_DAT_O,
  output logic        S_ACK_O,
  output logic        S_ERR_O,
  output logic        S_RTY_O
);

  localparam logic [31:0] WIN_MASK = ~((32'd4 << ADDR_WIDTH) - 32'd1);

  ram_state_t            state, state_next;
  logic [ADDR_WIDTH-1:0] counter, counter_next;
  logic [ADDR_WIDTH-1:0] adr_idx, cnt_inc, ram_addr;
  logic [31:0]           cnt_inc_full;
  logic [SEL_WIDTH-1:0]  ram_we;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  ram_en, req, hit, ack, err;
  logic                  unused_sig;

  assign req          = S_CYC_I & S_STB_I;
  assign hit          = (S_ADR_I & WIN_MASK) == BASE_ADDR;
  assign adr_idx      = S_ADR_I[ADDR_WIDTH+1:2];
  assign cnt_inc_full = next_index(32'(counter), S_BTE_I);
  assign cnt_inc      = cnt_inc_full[ADDR_WIDTH-1:0];
  assign unused_sig   = ^{S_LOCK_I, cnt_inc_full[31:ADDR_WIDTH]};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= ST_IDLE;
      counter <= '0;
    end else begin
      state   <= state_next;
      counter <= counter_next;
    end
  end

  always_comb begin
    state_next   = state;
    counter_next = counter;
    ram_en       = 1'b0;
    ram_we       = '0;
    ram_addr     = adr_idx;
    ack          = 1'b0;
    err          = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req) begin
          if (!hit) begin
            state_next = ST_ERROR;
          end else begin
            ram_en       = 1'b1;
            counter_next = adr_idx;
            state_next   = (S_CTI_I == LM32_CTYPE_INCREMENTING) ? ST_BURST : ST_SINGLE;
          end
        end
      end
      ST_SINGLE: begin
        state_next = ST_IDLE;
        if (req) begin
          ack = 1'b1;
          if (S_WE_I) begin
            ram_en = 1'b1;
            ram_we = S_SEL_I;
          end
        end
      end
      ST_BURST: begin
        if (!S_CYC_I) begin
          state_next = ST_IDLE;
        end else if (req && !hit) begin
          err        = 1'b1;
          state_next = ST_IDLE;
        end else if (req) begin
          // Prefetch the following beat so read data is ready with zero waits.
          ack          = 1'b1;
          counter_next = cnt_inc;
          ram_en       = 1'b1;
          if (S_WE_I) ram_we = S_SEL_I;
          else ram_addr = cnt_inc;
          if (S_CTI_I == LM32_CTYPE_END) state_next = ST_IDLE;
        end else begin
          ram_en   = 1'b1;
          ram_addr = counter;
        end
      end
      ST_ERROR: begin
        err        = req;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  lm32_wb_ram_array #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk   (clk_i),
    .rst   (rst_i),
    .en    (ram_en & ~rst_i),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (S_DAT_I),
    .rdata (ram_rdata)
  );

  assign S_DAT_O = ram_rdata;
  assign S_ACK_O = ack;
  assign S_ERR_O = err;
  assign S_RTY_O = 1'b0;

endmodule

// File: tb/tb_lm32_wb_ram_slave.sv
// Scoreboard bench for the Wishbone RAM slave: classic, byte-select, wrap and
// linear bursts with stalls, window errors and reset in the middle of a burst.
module tb_lm32_wb_ram_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] adr = '0;
  logic [31:0] dat_w = '0;
  logic [3:0]  sel = '0;
  logic        we = 1'b0;
  logic [2:0]  cti = '0;
  logic [1:0]  bte = '0;
  logic        lock = 1'b0;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic [31:0] dat_r;
  logic        ack, err, rty;

  int checks = 0;
  int failures = 0;
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  int last_acks, last_errs, last_cycles, gap_acks;
  bit last_timeout;
  bit proto_bad = 1'b0;

  lm32_wb_ram_slave #(
    .ADDR_WIDTH(11),
    .BASE_ADDR (32'h0000_0000)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .S_ADR_I (adr),
    .S_DAT_I (dat_w),
    .S_SEL_I (sel),
    .S_WE_I  (we),
    .S_CTI_I (cti),
    .S_BTE_I (bte),
    .S_LOCK_I(lock),
    .S_CYC_I (cyc),
    .S_STB_I (stb),
    .S_DAT_O (dat_r),
    .S_ACK_O (ack),
    .S_ERR_O (err),
    .S_RTY_O (rty)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] tb_next_adr(input logic [31:0] a, input logic [1:0] bt);
    logic [31:0] r;
    r = a;
    case (bt)
      2'b00:   r = a + 32'd4;
      2'b01:   r[3:2] = a[3:2] + 2'd1;
      2'b10:   r[4:2] = a[4:2] + 3'd1;
      default: r[5:2] = a[5:2] + 4'd1;
    endcase
    return r;
  endfunction

  task automatic bus_idle();
    cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000; bte = 2'b00; sel = 4'h0;
  endtask

  task automatic wb_single(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic w, input logic [2:0] c, input bit imm);
    bit done;
    int n;
    if (!imm) begin
      @(posedge clk); #1;
    end
    adr = a; dat_w = d; sel = s; we = w; cti = c; bte = 2'b00; cyc = 1'b1; stb = 1'b1;
    last_acks = 0; last_errs = 0; last_timeout = 1'b0; done = 1'b0; n = 0;
    while (!done && n < 16) begin
      @(negedge clk);
      n++;
      if (ack && err) proto_bad = 1'b1;
      if (ack) begin
        last_acks++;
        if (!w) got_q.push_back(dat_r);
        done = 1'b1;
      end else if (err) begin
        last_errs++;
        done = 1'b1;
      end else begin
        @(posedge clk);
      end
    end
    if (!done) last_timeout = 1'b1;
    last_cycles = n;
    @(posedge clk); #1;
    bus_idle();
  endtask

  task automatic wb_burst(input logic [31:0] a0, input int beats, input logic [1:0] bt,
                          input logic w, input logic [31:0] wbase, input int gap_after,
                          input int gap_len, input bit keep);
    logic [31:0] a;
    int beat, n;
    bit stop, acked;
    @(posedge clk); #1;
    last_acks = 0; last_errs = 0; last_timeout = 1'b0; gap_acks = 0;
    n = 0; beat = 0; stop = 1'b0; a = a0;
    cyc = 1'b1; we = w; bte = bt; sel = 4'hF;
    while (beat < beats && !stop && n < 64) begin
      adr = a;
      dat_w = wbase + 32'(beat);
      cti = (beat == beats - 1) ? 3'b111 : 3'b010;
      stb = 1'b1;
      @(negedge clk);
      n++;
      acked = ack;
      if (ack && err) proto_bad = 1'b1;
      if (ack) begin
        if (!w) got_q.push_back(dat_r);
        last_acks++;
        beat++;
        a = tb_next_adr(a, bt);
      end else if (err) begin
        last_errs++;
        stop = 1'b1;
      end
      @(posedge clk); #1;
      if (acked && beat == gap_after && gap_len > 0 && beat < beats) begin
        stb = 1'b0;
        repeat (gap_len) begin
          @(negedge clk);
          n++;
          if (ack || err) gap_acks++;
          @(posedge clk); #1;
        end
      end
    end
    if (beat < beats && !stop) last_timeout = 1'b1;
    last_cycles = n;
    if (!keep) bus_idle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_idle();
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (ack !== 1'b0 || err !== 1'b0 || rty !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags ack=%b err=%b rty=%b required 0/0/0", ack, err, rty);
    end
    checks++;
    if (dat_r !== 32'h0) begin
      failures++;
      $display("FAIL reset_data got=%h required=00000000", dat_r);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_classic();
    logic [31:0] g, e;
    wb_single(32'h10, 32'hDEADBEEF, 4'hF, 1'b1, 3'b000, 1'b0);
    checks++;
    if (last_acks !== 1 || last_errs !== 0 || last_cycles !== 2 || last_timeout) begin
      failures++;
      $display("FAIL classic_write acks=%0d errs=%0d cycles=%0d required 1/0/2", last_acks, last_errs, last_cycles);
    end
    exp_q.push_back(32'hDEADBEEF);
    wb_single(32'h10, 32'h0, 4'hF, 1'b0, 3'b000, 1'b0);
    checks++;
    if (last_acks !== 1 || last_errs !== 0 || last_cycles !== 2 || last_timeout) begin
      failures++;
      $display("FAIL classic_read acks=%0d errs=%0d cycles=%0d required 1/0/2", last_acks, last_errs, last_cycles);
    end
    exp_q.push_back(32'hDEADBEEF);
    wb_single(32'h10, 32'h0, 4'hF, 1'b0, 3'b001, 1'b0);
    checks++;
    if (last_acks !== 1 || last_cycles !== 2) begin
      failures++;
      $display("FAIL const_cti_read acks=%0d cycles=%0d required 1/2", last_acks, last_cycles);
    end
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      failures++;
      $display("FAIL classic_count got=%0d required=%0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL classic_data got=%h required=%h", g, e);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_byte_write();
    logic [31:0] g, e;
    wb_single(32'h10, 32'h0000_5500, 4'b0010, 1'b1, 3'b000, 1'b0);
    exp_q.push_back(32'hDEAD55EF);
    wb_single(32'h10, 32'h0, 4'hF, 1'b0, 3'b000, 1'b0);
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      failures++;
      $display("FAIL byte_count got=%0d required=%0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL byte_data got=%h required=%h", g, e);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_wrap_burst();
    logic [31:0] g, e;
    wb_burst(32'h20, 4, 2'b00, 1'b1, 32'd1, 0, 0, 1'b0);
    checks++;
    if (last_acks !== 4 || last_errs !== 0 || last_cycles !== 5 || last_timeout) begin
      failures++;
      $display("FAIL burst_write acks=%0d errs=%0d cycles=%0d required 4/0/5", last_acks, last_errs, last_cycles);
    end
    exp_q.push_back(32'd3); exp_q.push_back(32'd4); exp_q.push_back(32'd1); exp_q.push_back(32'd2);
    wb_burst(32'h28, 4, 2'b01, 1'b0, 32'd0, 0, 0, 1'b0);
    checks++;
    if (last_acks !== 4 || last_errs !== 0 || last_cycles !== 5 || last_timeout) begin
      failures++;
      $display("FAIL wrap4_handshake acks=%0d errs=%0d cycles=%0d required 4/0/5", last_acks, last_errs, last_cycles);
    end
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      failures++;
      $display("FAIL wrap4_count got=%0d required=%0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL wrap4_data got=%h required=%h", g, e);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [31:0] g, e;
    exp_q.push_back(32'd1); exp_q.push_back(32'd2); exp_q.push_back(32'd3); exp_q.push_back(32'd4);
    wb_burst(32'h20, 4, 2'b00, 1'b0, 32'd0, 0, 0, 1'b1);
    exp_q.push_back(32'd4);
    wb_single(32'h2C, 32'h0, 4'hF, 1'b0, 3'b000, 1'b1);
    checks++;
    if (last_acks !== 1 || last_cycles !== 2 || last_timeout) begin
      failures++;
      $display("FAIL b2b_after_end acks=%0d cycles=%0d required 1/2", last_acks, last_cycles);
    end
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      failures++;
      $display("FAIL b2b_count got=%0d required=%0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL b2b_data got=%h required=%h", g, e);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_linear_stall();
    logic [31:0] g, e;
    wb_burst(32'h40, 8, 2'b00, 1'b1, 32'h100, 0, 0, 1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(32'h100 + 32'(i));
    wb_burst(32'h40, 8, 2'b00, 1'b0, 32'd0, 3, 2, 1'b0);
    checks++;
    if (last_acks !== 8 || last_errs !== 0 || gap_acks !== 0 || last_cycles !== 11 || last_timeout) begin
      failures++;
      $display("FAIL stall_handshake acks=%0d errs=%0d gap_acks=%0d cycles=%0d required 8/0/0/11",
               last_acks, last_errs, gap_acks, last_cycles);
    end
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      failures++;
      $display("FAIL stall_count got=%0d required=%0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL stall_data got=%h required=%h", g, e);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_error();
    logic [31:0] g, e;
    logic [2:0] err_seen, ack_seen;
    wb_single(32'h0, 32'h0BAD_F00D, 4'hF, 1'b1, 3'b000, 1'b0);
    wb_single(32'h0001_0000, 32'hFFFF_FFFF, 4'hF, 1'b1, 3'b000, 1'b0);
    checks++;
    if (last_errs !== 1 || last_acks !== 0 || last_cycles !== 2) begin
      failures++;
      $display("FAIL oor_write errs=%0d acks=%0d cycles=%0d required 1/0/2", last_errs, last_acks, last_cycles);
    end
    // Hold an out-of-window strobe: ERR must pulse for a single cycle.
    @(posedge clk); #1;
    adr = 32'h0001_0000; we = 1'b0; sel = 4'hF; cti = 3'b000; cyc = 1'b1; stb = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      err_seen[i] = err;
      ack_seen[i] = ack;
      @(posedge clk); #1;
    end
    bus_idle();
    checks++;
    if (err_seen !== 3'b010 || ack_seen !== 3'b000) begin
      failures++;
      $display("FAIL err_pulse err=%b ack=%b required 010/000", err_seen, ack_seen);
    end
    exp_q.push_back(32'h0BAD_F00D);
    wb_single(32'h0, 32'h0, 4'hF, 1'b0, 3'b000, 1'b0);
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      failures++;
      $display("FAIL oor_count got=%0d required=%0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL oor_ram_unchanged got=%h required=%h", g, e);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_burst_overrun();
    logic [31:0] g, e;
    wb_single(32'h1FF8, 32'hCAFE_0001, 4'hF, 1'b1, 3'b000, 1'b0);
    wb_single(32'h1FFC, 32'hCAFE_0002, 4'hF, 1'b1, 3'b000, 1'b0);
    exp_q.push_back(32'hCAFE_0001); exp_q.push_back(32'hCAFE_0002);
    wb_burst(32'h1FF8, 4, 2'b00, 1'b0, 32'd0, 0, 0, 1'b0);
    checks++;
    if (last_acks !== 2 || last_errs !== 1 || last_cycles !== 4) begin
      failures++;
      $display("FAIL overrun acks=%0d errs=%0d cycles=%0d required 2/1/4", last_acks, last_errs, last_cycles);
    end
    exp_q.push_back(32'hCAFE_0002);
    wb_single(32'h1FFC, 32'h0, 4'hF, 1'b0, 3'b000, 1'b0);
    checks++;
    if (last_acks !== 1 || last_cycles !== 2) begin
      failures++;
      $display("FAIL overrun_then_idle acks=%0d cycles=%0d required 1/2", last_acks, last_cycles);
    end
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      failures++;
      $display("FAIL overrun_count got=%0d required=%0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL overrun_data got=%h required=%h", g, e);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid_burst();
    logic [31:0] g, e;
    logic [31:0] a;
    int beats;
    a = 32'h40; beats = 0;
    exp_q.push_back(32'h100); exp_q.push_back(32'h101);
    @(posedge clk); #1;
    adr = a; we = 1'b0; sel = 4'hF; cti = 3'b010; bte = 2'b00; cyc = 1'b1; stb = 1'b1;
    for (int i = 0; i < 8 && beats < 2; i++) begin
      @(negedge clk);
      if (ack) begin
        got_q.push_back(dat_r);
        beats++;
        a = a + 32'd4;
      end
      @(posedge clk); #1;
      adr = a;
    end
    checks++;
    if (beats !== 2) begin
      failures++;
      $display("FAIL rst_burst_beats got=%0d required=2", beats);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (ack !== 1'b0 || dat_r !== 32'h0) begin
      failures++;
      $display("FAIL rst_mid_burst ack=%b data=%h required 0/00000000", ack, dat_r);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bus_idle();
    exp_q.push_back(32'hDEAD55EF);
    wb_single(32'h10, 32'h0, 4'hF, 1'b0, 3'b000, 1'b0);
    exp_q.push_back(32'h102);
    wb_single(32'h48, 32'h0, 4'hF, 1'b0, 3'b000, 1'b0);
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      failures++;
      $display("FAIL rst_count got=%0d required=%0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL rst_data got=%h required=%h", g, e);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_protocol();
    checks++;
    if (proto_bad !== 1'b0) begin
      failures++;
      $display("FAIL ack_err_overlap seen=%b required=0", proto_bad);
    end
  endtask

  initial begin
    test_reset();
    test_classic();
    test_byte_write();
    test_wrap_burst();
    test_back_to_back();
    test_linear_stall();
    test_error();
    test_burst_overrun();
    test_reset_mid_burst();
    test_protocol();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lm32_wb_ram_slave.md
Name: lm32_wb_ram_slave

Overview:
Wishbone B3 slave that serves on-chip single-port RAM to the LM32 data or instruction Wishbone master. It supports classic cycles and registered-feedback incrementing bursts (CTI/BTE), with byte-select writes. Any address outside the decoded window terminates with an error. It sits on the SoC bus next to the CPU and is the responder for the CPU's D_*/I_* master ports.

Parameters:
ADDR_WIDTH, 11, word-address bits; memory depth is 2**ADDR_WIDTH 32-bit words (8 KiB by default).
BASE_ADDR, 32'h0000_0000, byte base of the decoded window; must be aligned to 4*2**ADDR_WIDTH.

Ports:
clk_i  in  1  clock; all logic is on the rising edge
rst_i  in  1  synchronous, active-high reset
S_ADR_I  in  32  byte address; bits [1:0] are ignored
S_DAT_I  in  32  write data
S_SEL_I  in  4  byte select; bit n enables byte lane [8n+7:8n]
S_WE_I  in  1  write enable
S_CTI_I  in  3  cycle type: 000 classic, 001 constant, 010 increment, 111 end-of-burst
S_BTE_I  in  2  burst type: 00 linear, 01 wrap4, 10 wrap8, 11 wrap16
S_LOCK_I  in  1  ignored
S_CYC_I  in  1  cycle
S_STB_I  in  1  strobe
S_DAT_O  out  32  read data
S_ACK_O  out  1  acknowledge
S_ERR_O  out  1  error
S_RTY_O  out  1  retry; tied to 0

Behaviour:
- Address decode:
  - hit = (S_ADR_I & ~(4*2**ADDR_WIDTH-1)) == BASE_ADDR.
  - Word index = S_ADR_I[ADDR_WIDTH+1:2].
- States: IDLE, SINGLE, BURST, ERROR.
- Reset (synchronous): state=IDLE; S_ACK_O=0, S_ERR_O=0, S_DAT_O=0; burst counter=0. RAM contents are not cleared. Reset mid-burst gives IDLE on the next cycle with no ack.
- Output equations:
  - S_ACK_O = CYC&STB&(state==SINGLE | state==BURST & hit).
  - S_ERR_O = registered; 1 for exactly one cycle in state ERROR, or combinationally in BURST when CYC&STB&!hit.
- IDLE:
  - On CYC&STB&!hit: go to ERROR. ERR_O=1 the next cycle, then back to IDLE. No RAM access.
  - On CYC&STB&hit: RAM read issued at the word index and burst counter loaded with it. If CTI==010 go to BURST, else go to SINGLE.
- SINGLE:
  - ACK_O=1 and S_DAT_O holds RAM[index].
  - If WE, bytes with SEL=1 are written from S_DAT_I/S_ADR_I on this cycle.
  - Then IDLE. Classic latency is 1 wait state: ACK in the 2nd cycle of STB.
- BURST:
  - ACK is asserted on every cycle with CYC&STB&hit (zero wait state per beat after the first).
  - RAM read address = beat acked ? next(counter) : counter, so S_DAT_O always holds the current beat's word.
  - counter advances only on an acked beat. STB low with CYC high gives ACK=0 and holds counter and S_DAT_O.
- next(counter), on the low bits only:
  - linear = counter+1, wrapping modulo 2**ADDR_WIDTH.
  - wrap4 = increment bits[1:0] with upper bits held; wrap8 = bits[2:0]; wrap16 = bits[3:0].
- Writes in a burst: on each acked beat, at S_ADR_I (not the counter) with SEL masking.
- Burst exit:
  - An acked beat with CTI==111 goes to IDLE; a new cycle can start one cycle later.
  - CYC low goes to IDLE immediately, with no ack.
  - An out-of-range beat (!hit) asserts ERR instead of ACK and goes to IDLE.
- Read-during-write to the same word: S_DAT_O returns the old data; the new data is visible from the next read onward.
- CTI==001 is treated as classic, one SINGLE access per strobe.
- ACK and ERR are never asserted together, and never asserted when CYC_I=0.

Decomposition:
- Shared include:
  - CTI/BTE encodings (the existing LM32_CTYPE_*/LM32_BTYPE_* defines, plus LM32_CTYPE_END=3'b111).
  - State encoding constants for this block.
- Sub-module lm32_wb_ram_array:
  - Synchronous-read single-port RAM, 32-bit with 4 byte-write enables, depth 2**ADDR_WIDTH.
  - Inferred EBR; no registered output.

Test Plan:
- Reset, then classic write 0xDEADBEEF to 0x0000_0010 with SEL=1111, then classic read -> ACK in the 2nd cycle of each strobe; read returns 0xDEADBEEF; ERR=0 throughout.
- Byte write SEL=0010, DAT=0x0000_5500 to 0x10, then read -> 0xDEAD55EF.
- Preload words 0x20..0x2C with 1,2,3,4. Incrementing read burst, BTE=01, start address 0x28, CTI 010,010,010,111 -> consecutive acks returning 3,4,1,2; IDLE after the 4th beat.
- Linear burst read of 8 beats with STB low for 2 cycles after beat 3 -> no ACK during the gap; beat 4 returns word 4 (not skipped or duplicated).
- Access to 0x0001_0000 with ADDR_WIDTH=11 -> ERR for one cycle, no ACK, RAM unchanged; linear burst running off the top of the window -> ERR on the first out-of-range beat, then IDLE.
- rst_i asserted mid-burst after beat 2 -> ACK=0, S_DAT_O=0 next cycle; subsequent classic read of a previously written word returns its value.
